// File: rtl/dpctl_pkg.sv
// dpctl_pkg: shared types and encodings for the datapath controller
package dpctl_pkg;
  localparam int DATA_W = 16;
  localparam int RADDR_W = 3;
  typedef enum logic [2:0] {S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_ALU, S_WR_REG} state_t;
  typedef enum logic [1:0] {NSEL_NONE, NSEL_RN, NSEL_RD, NSEL_RM} nsel_t;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b00;
endpackage

// File: rtl/datapath_controller_instr_decoder.sv
// instr_decoder: splits the IR into fields, flags instruction class and muxes register numbers
module instr_decoder
  import dpctl_pkg::*;
(
  input  logic [DATA_W-1:0]  ir,
  input  nsel_t              rsel,
  input  nsel_t              wsel,
  output logic [1:0]         op,
  output logic [1:0]         sh,
  output logic [DATA_W-1:0]  sximm8,
  output logic               legal,
  output logic               mov_imm,
  output logic               mov_reg,
  output logic [RADDR_W-1:0] readnum,
  output logic [RADDR_W-1:0] writenum
);
  logic [2:0] opcode;
  logic [RADDR_W-1:0] rn, rd, rm;
  function automatic logic [RADDR_W-1:0] pick(input nsel_t n, input logic [RADDR_W-1:0] a, b, c);
    return n == NSEL_RN ? a : n == NSEL_RD ? b : n == NSEL_RM ? c : '0;
  endfunction
  assign opcode   = ir[15:13];
  assign op       = ir[12:11];
  assign rn       = ir[10:8];
  assign rd       = ir[7:5];
  assign sh       = ir[4:3];
  assign rm       = ir[2:0];
  assign sximm8   = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign mov_imm  = opcode == OPC_MOV && op == OP_MOV_IMM;
  assign mov_reg  = opcode == OPC_MOV && op == OP_MOV_REG;
  assign legal    = mov_imm || mov_reg || opcode == OPC_ALU;
  assign readnum  = pick(rsel, rn, rd, rm);
  assign writenum = pick(wsel, rn, rd, rm);
endmodule

// File: rtl/datapath_controller.sv
// datapath_controller: instruction register plus Moore FSM sequencing the 16-bit datapath
module datapath_controller
  import dpctl_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  instr_in,
  input  logic               load,
  input  logic               s,
  output logic               w,
  output logic               illegal,
  output logic [DATA_W-1:0]  datapath_in,
  output logic               vsel,
  output logic [RADDR_W-1:0] writenum,
  output logic [RADDR_W-1:0] readnum,
  output logic               write,
  output logic               loada,
  output logic               loadb,
  output logic               asel,
  output logic               bsel,
  output logic [1:0]         shift,
  output logic [1:0]         ALUop,
  output logic               loadc,
  output logic               loads
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] ir_q;
  logic [1:0] op, sh;
  logic legal, mov_imm, mov_reg, cmp;
  nsel_t rsel, wsel;
  instr_decoder u_dec (
    .ir(ir_q), .rsel(rsel), .wsel(wsel), .op(op), .sh(sh), .sximm8(datapath_in),
    .legal(legal), .mov_imm(mov_imm), .mov_reg(mov_reg), .readnum(readnum), .writenum(writenum)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load && state_q == S_WAIT) ir_q <= instr_in;
    end
  assign cmp = !mov_reg && op == OP_CMP;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   state_d = s ? S_DECODE : S_WAIT;
      S_DECODE: state_d = !legal ? S_WAIT : mov_imm ? S_WR_IMM : mov_reg ? S_GET_B : S_GET_A;
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_ALU;
      S_ALU:    state_d = cmp ? S_WAIT : S_WR_REG;
      default:  state_d = S_WAIT;
    endcase
  end
  assign w       = state_q == S_WAIT;
  assign illegal = state_q == S_DECODE && !legal;
  assign vsel    = state_q == S_WR_IMM;
  assign write   = state_q == S_WR_IMM || state_q == S_WR_REG;
  assign wsel    = state_q == S_WR_IMM ? NSEL_RN : state_q == S_WR_REG ? NSEL_RD : NSEL_NONE;
  assign rsel    = state_q == S_GET_A ? NSEL_RN : state_q == S_GET_B ? NSEL_RM : NSEL_NONE;
  assign loada   = state_q == S_GET_A;
  assign loadb   = state_q == S_GET_B;
  assign asel    = state_q == S_ALU && mov_reg;
  assign bsel    = 1'b0;
  assign shift   = state_q == S_ALU ? sh : 2'b00;
  assign ALUop   = state_q == S_ALU && !mov_reg ? op : ALU_ADD;
  assign loadc   = state_q == S_ALU && !cmp;
  assign loads   = state_q == S_ALU && cmp;
endmodule

// File: tb/tb_datapath_controller.sv
// tb_datapath_controller: controller driving a behavioural datapath, checked against an ISA-level model
module tb_datapath_controller;
  logic clk = 0;
  logic reset_n = 0;
  logic [15:0] instr_in = '0;
  logic load = 0, s = 0;
  logic w, illegal, vsel, write, loada, loadb, asel, bsel, loadc, loads;
  logic [15:0] datapath_in;
  logic [2:0] writenum, readnum;
  logic [1:0] shift, ALUop;
  always #5 clk = ~clk;

  datapath_controller dut (
    .clk(clk), .reset_n(reset_n), .instr_in(instr_in), .load(load), .s(s), .w(w), .illegal(illegal),
    .datapath_in(datapath_in), .vsel(vsel), .writenum(writenum), .readnum(readnum), .write(write),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .loadc(loadc), .loads(loads)
  );

  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] k);
    return k == 2'd0 ? v : k == 2'd1 ? {v[14:0], 1'b0} : k == 2'd2 ? {1'b0, v[15:1]} : {v[15], v[15:1]};
  endfunction

  // behavioural datapath the controller steers
  logic [15:0] r [8] = '{default: 16'h0};
  logic [15:0] a = '0, b = '0, c = '0;
  logic z = 0;
  logic [15:0] ain, bin, alu_out;
  assign ain = asel ? 16'h0 : a;
  assign bin = bsel ? 16'h0 : shf(b, shift);
  assign alu_out = ALUop == 2'd0 ? ain + bin : ALUop == 2'd1 ? ain - bin : ALUop == 2'd2 ? ain & bin : ~bin;
  always @(posedge clk) begin
    if (write) r[writenum] <= vsel ? datapath_in : c;
    if (loada) a <= r[readnum];
    if (loadb) b <= r[readnum];
    if (loadc) c <= alu_out;
    if (loads) z <= alu_out == 16'h0;
  end

  int pass_cnt = 0, tot_cnt = 0;
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
  endtask

  function automatic logic [127:0] pack(input logic [15:0] v [8]);
    logic [127:0] p;
    for (int i = 0; i < 8; i++) p[i*16 +: 16] = v[i];
    return p;
  endfunction

  // ISA-level reference model and scoreboard
  typedef struct { logic [127:0] regs; logic z; int lat; int ill; } exp_t;
  exp_t q[$];
  logic [15:0] m_r [8] = '{default: 16'h0};
  logic m_z = 0;
  task automatic model(input logic [15:0] ins);
    exp_t e;
    logic [15:0] sv;
    logic [2:0] rn, rd;
    rn = ins[10:8];
    rd = ins[7:5];
    sv = shf(m_r[ins[2:0]], ins[4:3]);
    e.ill = 0;
    if (ins[15:11] == 5'b11010) begin m_r[rn] = {{8{ins[7]}}, ins[7:0]}; e.lat = 2; end
    else if (ins[15:11] == 5'b11000) begin m_r[rd] = sv; e.lat = 4; end
    else if (ins[15:13] == 3'b101) begin
      e.lat = 5;
      case (ins[12:11])
        2'd0: m_r[rd] = m_r[rn] + sv;
        2'd1: begin m_z = (m_r[rn] - sv) == 16'h0; e.lat = 4; end
        2'd2: m_r[rd] = m_r[rn] & sv;
        default: m_r[rd] = ~sv;
      endcase
    end else begin e.lat = 1; e.ill = 1; end
    e.regs = pack(m_r);
    e.z = m_z;
    q.push_back(e);
  endtask

  bit mon_en = 1;
  int lat = 0, ill = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (!mon_en) begin lat = 0; ill = 0; end
    else if (!w) begin lat++; if (illegal) ill++; end
    else if (lat > 0) begin
      if (q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("regs", pack(r), e.regs);
        chk("z", z, e.z);
        chk("latency", lat, e.lat);
        chk("illegal_cycles", ill, e.ill);
      end
      lat = 0;
      ill = 0;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && !w; i++) @(negedge clk);
    chk("idle_timeout", w, 1);
  endtask

  task automatic issue(input logic [15:0] ins, input bit split);
    @(negedge clk);
    instr_in = ins;
    load = 1;
    if (split) begin @(negedge clk); load = 0; end
    s = 1;
    model(ins);
    @(negedge clk);
    load = 0;
    s = 0;
    wait_idle();
  endtask

  initial begin
    logic [15:0] ins;
    repeat (2) @(negedge clk);
    chk("rst_w", w, 1);
    chk("rst_ctrl", {illegal, vsel, write, loada, loadb, asel, bsel, loadc, loads, shift, ALUop, readnum, writenum}, 0);
    chk("rst_dp_in", datapath_in, 0);
    reset_n = 1;
    issue(16'hD007, 0);
    issue(16'hD102, 1);
    // abort ADD R4,R1,R0 in GET_B: R4 must stay 0
    mon_en = 0;
    @(negedge clk);
    instr_in = 16'hA188; load = 1; s = 1;
    @(negedge clk);
    load = 0; s = 0;
    repeat (2) @(negedge clk);
    chk("in_get_b", loadb, 1);
    reset_n = 0;
    #1;
    chk("abort_w", w, 1);
    chk("abort_write", write, 0);
    repeat (2) @(negedge clk);
    chk("abort_r4", r[4], m_r[4]);
    chk("abort_ir", datapath_in, 0);
    reset_n = 1;
    @(negedge clk);
    mon_en = 1;
    issue(16'hA148, 0);
    issue(16'hD3FF, 1);
    chk("sximm8", datapath_in, 16'hFFFF);
    issue(16'hB860, 0);
    issue(16'hA800, 0);
    issue(16'hE000, 0);
    // load during ADD is ignored; s alone then reruns the same IR
    @(negedge clk);
    instr_in = 16'hA148; load = 1; s = 1;
    model(16'hA148);
    @(negedge clk);
    instr_in = 16'hD0FF; s = 0;
    @(negedge clk);
    load = 0;
    wait_idle();
    @(negedge clk);
    s = 1;
    model(16'hA148);
    @(negedge clk);
    s = 0;
    wait_idle();
    for (int n = 0; n < 40; n++) begin
      int k;
      k = $urandom_range(0, 6);
      ins = 16'($urandom);
      if (k == 0) ins[15:11] = 5'b11010;
      else if (k == 1) ins[15:11] = 5'b11000;
      else if (k < 6) ins[15:13] = 3'b101;
      else begin
        ins[15:13] = 3'($urandom_range(0, 7));
        if (ins[15:13] == 3'b101) ins[15:13] = 3'b111;
        if (ins[15:13] == 3'b110) ins[12:11] = ins[12] ? 2'b11 : 2'b01;
      end
      issue(ins, 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
